// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
//   FWD_SEL_*  : ALU operand mux select encodings (2'b11 is never used)
//   *_tag_t    : per-stage destination/source tags tracked by fwd_hazard_unit
package fwd_pkg;

    localparam int unsigned FWD_REG_AW = 5;
    localparam int unsigned FWD_CNT_W  = 32;

    localparam logic [1:0] FWD_SEL_RF    = 2'b00;
    localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
    localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

    typedef logic [FWD_REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t rd;
        logic     wr;
        logic     ld;
        logic     v;
    } ex_tag_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     wr;
        logic     ld;
    } mem_tag_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     wr;
    } wb_tag_t;

    // A stage can supply a source operand if it writes a nonzero register equal to it.
    function automatic logic tag_hit(input reg_idx_t rd, input logic wr, input reg_idx_t src);
        return wr && (rd != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Operand forwarding select for one ALU source.
//   src_i      : source register index of the instruction in EX
//   ex_v_i     : EX holds a real instruction (bubble -> register file)
//   mem_rd_i/mem_wr_i, wb_rd_i/wb_wr_i : destination tags of MEM and WB
//   sel_c_o    : combinational 2-bit mux select (never 2'b11)
module fwd_sel_cmp
    import fwd_pkg::*;
(
    input  reg_idx_t   src_i,
    input  logic       ex_v_i,
    input  reg_idx_t   mem_rd_i,
    input  logic       mem_wr_i,
    input  reg_idx_t   wb_rd_i,
    input  logic       wb_wr_i,
    output logic [1:0] sel_c_o
);

    // MEM is checked first: it holds the younger result.
    always_comb begin
        sel_c_o = FWD_SEL_RF;
        if (ex_v_i) begin
            if (tag_hit(mem_rd_i, mem_wr_i, src_i)) begin
                sel_c_o = FWD_SEL_EXMEM;
            end else if (tag_hit(wb_rd_i, wb_wr_i, src_i)) begin
                sel_c_o = FWD_SEL_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit, placed between ID and the EX operand muxes.
// Tracks EX/MEM/WB destination tags fed from decode and produces:
//   fwd_a_sel, fwd_b_sel : operand mux selects for the instruction in EX (combinational)
//   stall                : load-use stall request (combinational from ID + EX tag)
//   fwd_cnt, stall_cnt   : saturating event counters, present only with `FWD_PERF_EN
// Inputs: clk, rst_n (async active-low), id_valid, id_rs, id_rt, id_wr_reg,
//         id_reg_write, id_mem_read, flush.
// Build option: define FWD_PERF_EN to add the performance counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW = FWD_REG_AW
`ifdef FWD_PERF_EN
    ,
    parameter int unsigned CNT_W  = FWD_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
`ifdef FWD_PERF_EN
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic              stall
);

    ex_tag_t  ex_q,  ex_d;
    mem_tag_t mem_q, mem_d;
    wb_tag_t  wb_q,  wb_d;

    logic     stall_c;
    reg_idx_t id_rs_t;
    reg_idx_t id_rt_t;
    reg_idx_t id_rd_t;

    assign id_rs_t = reg_idx_t'(id_rs);
    assign id_rt_t = reg_idx_t'(id_rt);
    assign id_rd_t = reg_idx_t'(id_wr_reg);

    // Load in EX whose result is needed by the instruction in ID; flush wins.
    always_comb begin
        stall_c = id_valid && !flush && ex_q.ld && ex_q.wr && (ex_q.rd != '0)
                  && ((ex_q.rd == id_rs_t) || (ex_q.rd == id_rt_t));
    end

    assign stall = stall_c;

    // Next-state tags: EX gets a bubble on flush, stall or empty decode.
    always_comb begin
        ex_d = '0;
        if (id_valid && !flush && !stall_c) begin
            ex_d.rs = id_rs_t;
            ex_d.rt = id_rt_t;
            ex_d.rd = id_rd_t;
            ex_d.wr = id_reg_write;
            ex_d.ld = id_mem_read;
            ex_d.v  = 1'b1;
        end
        mem_d.rd = ex_q.rd;
        mem_d.wr = ex_q.wr;
        mem_d.ld = ex_q.ld;
        wb_d.rd  = mem_q.rd;
        wb_d.wr  = mem_q.wr;
    end

    // Stage tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // The MEM load flag is tracked for completeness; WB resolves load data by forwarding.
    logic unused_mem_ld;
    assign unused_mem_ld = mem_q.ld;

    fwd_sel_cmp u_sel_a (
        .src_i    (ex_q.rs),
        .ex_v_i   (ex_q.v),
        .mem_rd_i (mem_q.rd),
        .mem_wr_i (mem_q.wr),
        .wb_rd_i  (wb_q.rd),
        .wb_wr_i  (wb_q.wr),
        .sel_c_o  (fwd_a_sel)
    );

    fwd_sel_cmp u_sel_b (
        .src_i    (ex_q.rt),
        .ex_v_i   (ex_q.v),
        .mem_rd_i (mem_q.rd),
        .mem_wr_i (mem_q.wr),
        .wb_rd_i  (wb_q.rd),
        .wb_wr_i  (wb_q.wr),
        .sel_c_o  (fwd_b_sel)
    );

`ifdef FWD_PERF_EN
    logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters.
    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (((fwd_a_sel != FWD_SEL_RF) || (fwd_b_sel != FWD_SEL_RF)) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: scripted instruction streams with
// hand-derived expected {fwd_a_sel, fwd_b_sel, stall} pushed per driven cycle.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_wr_reg;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
`ifdef FWD_PERF_EN
    logic [31:0] fwd_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;
    logic [4:0] exp_q[$];

    fwd_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_wr_reg    (id_wr_reg),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
`ifdef FWD_PERF_EN
        .fwd_cnt      (fwd_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input int rd,
                         input logic wr, input logic ld, input logic fl);
        id_valid     = v;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_wr_reg    = 5'(rd);
        id_reg_write = wr;
        id_mem_read  = ld;
        flush        = fl;
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic check_out(input string tag);
        logic [4:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {27'd0, fwd_a_sel, fwd_b_sel, stall}, {27'd0, e});
        end
    endtask

    // One pipeline cycle: drive ID, expect outputs for the instruction now in EX.
    task automatic step(input logic v, input int rs, input int rt, input int rd,
                        input logic wr, input logic ld, input logic fl,
                        input logic [1:0] ea, input logic [1:0] eb, input logic es);
        step_no++;
        drive(v, rs, rt, rd, wr, ld, fl);
        exp_q.push_back({ea, eb, es});
        @(negedge clk);
        check_out($sformatf("step%0d", step_no));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] ea, input logic [1:0] eb);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b0);
    endtask

    task automatic drain();
        idle(2'b00, 2'b00);
        idle(2'b00, 2'b00);
    endtask

    // add r3,r1,r2 ; sub r4,r3,r5
    task automatic seq_ex_mem();
        step(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0);
        step(1, 3, 5, 4, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b01, 2'b00);
        drain();
    endtask

    // lw r2,0(r1) ; add r4,r2,r2
    task automatic seq_load_use();
        step(1, 1, 0, 2, 1, 1, 0, 2'b00, 2'b00, 0);
        step(1, 2, 2, 4, 1, 0, 0, 2'b00, 2'b00, 1);
        step(1, 2, 2, 4, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b10, 2'b10);
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a", 32'(fwd_a_sel), 32'd0);
        chk("reset_b", 32'(fwd_b_sel), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
`ifdef FWD_PERF_EN
        chk("reset_fwd_cnt", fwd_cnt, 32'd0);
        chk("reset_stall_cnt", stall_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        seq_ex_mem();

        // add r3 ; nop ; or r6,r7,r3 -> B from MEM/WB
        step(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        step(1, 7, 3, 6, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b10);
        drain();

        // add r3 ; add r3 ; and r8,r3,r3 -> MEM wins over WB
        step(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0);
        step(1, 4, 5, 3, 1, 0, 0, 2'b00, 2'b00, 0);
        step(1, 3, 3, 8, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b01, 2'b01);
        drain();

        seq_load_use();

        // lw r2 ; lw r5,0(r2) ; add r6,r5,r0 -> chained loads, one stall each
        step(1, 1, 0, 2, 1, 1, 0, 2'b00, 2'b00, 0);
        step(1, 2, 0, 5, 1, 1, 0, 2'b00, 2'b00, 1);
        step(1, 2, 0, 5, 1, 1, 0, 2'b00, 2'b00, 0);
        step(1, 5, 0, 6, 1, 0, 0, 2'b10, 2'b00, 1);
        step(1, 5, 0, 6, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b10, 2'b00);
        drain();

        // add r0 ; sub r4,r0,r0 -> r0 never forwards
        step(1, 1, 2, 0, 1, 0, 0, 2'b00, 2'b00, 0);
        step(1, 0, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b00);
        drain();

        // lw r0 ; add r7,r0,r0 -> no stall on r0
        step(1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
        step(1, 0, 0, 7, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b00);
        drain();

        // lw r2 ; flushed add r4,r2,r2 -> no stall, EX bubble (else A/B would be 01)
        step(1, 1, 0, 2, 1, 1, 0, 2'b00, 2'b00, 0);
        step(1, 2, 2, 4, 1, 0, 1, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b00);
        drain();

        // lw r2 ; invalid decode naming r2 -> no stall
        step(1, 1, 0, 2, 1, 1, 0, 2'b00, 2'b00, 0);
        step(0, 2, 2, 4, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b00);
        drain();

        // add r7 ; lw r3,0(r7) ; add r4,r3,r5 held in ID, then async reset
        step(1, 1, 2, 7, 1, 0, 0, 2'b00, 2'b00, 0);
        step(1, 7, 0, 3, 1, 1, 0, 2'b00, 2'b00, 0);
        drive(1, 3, 5, 4, 1, 0, 0);
        exp_q.push_back({2'b01, 2'b00, 1'b1});
        @(negedge clk);
        check_out("pre_rst");
        rst_n = 1'b0;
        exp_q.push_back({2'b00, 2'b00, 1'b0});
        #1;
        check_out("mid_rst");
`ifdef FWD_PERF_EN
        chk("mid_rst_fwd_cnt", fwd_cnt, 32'd0);
        chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 3, 5, 4, 1, 0, 0, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b00);
        drain();

        // Scripted events after reset: two forwarding cycles, one stall cycle.
        seq_ex_mem();
        seq_load_use();
`ifdef FWD_PERF_EN
        chk("fwd_cnt", fwd_cnt, 32'd2);
        chk("stall_cnt", stall_cnt, 32'd1);
`endif
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
